// File: rtl/tictactoe_pkg.sv
// Shared cell codes, FSM encoding and position limits for the tic-tac-toe board logic.
package tictactoe_pkg;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_COMP   = 2'b10;

    localparam logic [3:0] POS_MIN = 4'd1;
    localparam logic [3:0] POS_MAX = 4'd9;
    localparam int         NUM_CELLS = 9;

    typedef enum logic [1:0] {
        ST_P_WAIT = 2'd0,
        ST_C_WAIT = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic pos_valid(input logic [3:0] p);
        return (p >= POS_MIN) && (p <= POS_MAX);
    endfunction

endpackage

// File: rtl/board_position_writer_rise_detect.sv
// One-bit rising-edge detector: a level held high yields a single-cycle request.
module rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) d_q <= 1'b0;
        else         d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/board_position_writer.sv
// Sole writer of the nine board cells: validates player/computer moves, alternates turns,
// and freezes the board once the game is over.
module board_position_writer
    import tictactoe_pkg::*;
#(
    parameter bit PLAYER_FIRST = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       play,
    input  logic       pc,
    input  logic [3:0] player_position,
    input  logic [3:0] computer_position,
    input  logic       game_done,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic       player_turn,
    output logic       illegal_move,
    output logic       write_strobe
);

    localparam state_e INIT_STATE = PLAYER_FIRST ? ST_P_WAIT : ST_C_WAIT;

    logic       play_req;
    logic       pc_req;
    state_e     state_q;
    logic [1:0] board_q [NUM_CELLS];
    logic       illegal_q;
    logic       strobe_q;
    logic [3:0] p_idx;
    logic [3:0] c_idx;
    logic       p_ok;
    logic       c_ok;

    rise_detect u_play_rise (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (play),
        .rise_o (play_req)
    );

    rise_detect u_pc_rise (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (pc),
        .rise_o (pc_req)
    );

    assign p_idx = player_position - 4'd1;
    assign c_idx = computer_position - 4'd1;

    // Range check gates the array lookup so out-of-range positions never index the board.
    always_comb begin
        p_ok = 1'b0;
        c_ok = 1'b0;
        if (pos_valid(player_position))   p_ok = (board_q[p_idx] == CELL_EMPTY);
        if (pos_valid(computer_position)) c_ok = (board_q[c_idx] == CELL_EMPTY);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= INIT_STATE;
            board_q   <= '{default: CELL_EMPTY};
            illegal_q <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            strobe_q  <= 1'b0;
            case (state_q)
                ST_P_WAIT: begin
                    if (game_done) begin
                        state_q <= ST_DONE;
                    end else if (play_req) begin
                        if (p_ok) begin
                            board_q[p_idx] <= CELL_PLAYER;
                            strobe_q       <= 1'b1;
                            state_q        <= ST_C_WAIT;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                ST_C_WAIT: begin
                    if (game_done) begin
                        state_q <= ST_DONE;
                    end else if (pc_req) begin
                        if (c_ok) begin
                            board_q[c_idx] <= CELL_COMP;
                            strobe_q       <= 1'b1;
                            state_q        <= ST_P_WAIT;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                ST_DONE:  state_q <= ST_DONE;
                default:  state_q <= INIT_STATE;
            endcase
        end
    end

    assign pos1 = board_q[0];
    assign pos2 = board_q[1];
    assign pos3 = board_q[2];
    assign pos4 = board_q[3];
    assign pos5 = board_q[4];
    assign pos6 = board_q[5];
    assign pos7 = board_q[6];
    assign pos8 = board_q[7];
    assign pos9 = board_q[8];

    assign player_turn  = (state_q == ST_P_WAIT);
    assign illegal_move = illegal_q;
    assign write_strobe = strobe_q;

endmodule
